// File: rtl/word_display_ctrl.sv
// word_display_ctrl: status-word FSM and 4-digit 7-segment refresh multiplexer.
// Define WORD_RECOVER_EN to let LOSE return to PLAY when eq drops.
module word_display_ctrl #(
    parameter int REFRESH_BITS = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       eq,
    input  logic       force_win,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic [1:0] word_sel
);
    typedef enum logic [1:0] {
        PLAY  = 2'b00,
        LOSE  = 2'b01,
        ILL_2 = 2'b10,
        ILL_3 = 2'b11
    } state_t;

    // Active-high segment sets, bit0=a ... bit6=g
    localparam logic [6:0] CH_P    = 7'b1110011;
    localparam logic [6:0] CH_L    = 7'b0111000;
    localparam logic [6:0] CH_A    = 7'b1110111;
    localparam logic [6:0] CH_Y    = 7'b1101110;
    localparam logic [6:0] CH_O    = 7'b0111111;
    localparam logic [6:0] CH_S    = 7'b1101101;
    localparam logic [6:0] CH_E    = 7'b1111001;
    localparam logic [6:0] CH_G    = 7'b0111101;
    localparam logic [6:0] CH_D    = 7'b1011110;
    localparam logic [6:0] CH_DASH = 7'b1000000;

    state_t                  state;
    logic [REFRESH_BITS-1:0] count;
    logic [1:0]              k;
    logic [6:0]              lit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= PLAY;
            count <= '0;
        end else begin
            count <= count + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
            case (state)
                PLAY:    state <= eq ? LOSE : PLAY;
`ifdef WORD_RECOVER_EN
                LOSE:    state <= eq ? LOSE : PLAY;
`else
                LOSE:    state <= LOSE;
`endif
                default: state <= PLAY;
            endcase
        end
    end

    assign k        = count[REFRESH_BITS-1 -: 2];
    assign word_sel = force_win ? 2'b10 : state;
    assign an       = ~(4'b0001 << k);
    assign seg      = ~lit;

    // k=3 is the leftmost character of the word
    always_comb begin
        lit = CH_DASH;
        case ({word_sel, k})
            4'b00_11: lit = CH_P;
            4'b00_10: lit = CH_L;
            4'b00_01: lit = CH_A;
            4'b00_00: lit = CH_Y;
            4'b01_11: lit = CH_L;
            4'b01_10: lit = CH_O;
            4'b01_01: lit = CH_S;
            4'b01_00: lit = CH_E;
            4'b10_11: lit = CH_G;
            4'b10_10: lit = CH_O;
            4'b10_01: lit = CH_O;
            4'b10_00: lit = CH_D;
            default:  lit = CH_DASH;
        endcase
    end
endmodule

// File: tb/tb_word_display_ctrl.sv
// tb_word_display_ctrl: directed checks of word_display_ctrl with REFRESH_BITS=4.
module tb_word_display_ctrl;
    logic       clk = 1'b0;
    logic       rst_n, eq, force_win;
    logic [6:0] seg;
    logic [3:0] an;
    logic [1:0] word_sel;
    int         vecs = 0;
    int         errs = 0;
    int         c = 0;
    logic [6:0] wtab [4][4];
    logic [3:0] atab [4];

`ifdef WORD_RECOVER_EN
    localparam bit REC = 1'b1;
`else
    localparam bit REC = 1'b0;
`endif

    word_display_ctrl #(.REFRESH_BITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .eq(eq), .force_win(force_win),
        .seg(seg), .an(an), .word_sel(word_sel)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        c = rst_n ? (c + 1) % 16 : 0;
    endtask

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk_digit(input string tag, input int w);
        chk({tag, "_an"}, {3'b000, an}, {3'b000, atab[c / 4]});
        chk({tag, "_seg"}, seg, wtab[w][c / 4]);
    endtask

    task automatic scan(input string tag, input int w, input int n);
        for (int i = 0; i < n; i++) begin
            chk_digit(tag, w);
            tick();
        end
    endtask

    initial begin
        // wtab[word][k], seg active low, k=0 is the rightmost digit
        wtab[0][3] = 7'b0001100; wtab[0][2] = 7'b1000111; wtab[0][1] = 7'b0001000; wtab[0][0] = 7'b0010001;
        wtab[1][3] = 7'b1000111; wtab[1][2] = 7'b1000000; wtab[1][1] = 7'b0010010; wtab[1][0] = 7'b0000110;
        wtab[2][3] = 7'b1000010; wtab[2][2] = 7'b1000000; wtab[2][1] = 7'b1000000; wtab[2][0] = 7'b0100001;
        wtab[3][3] = 7'b0111111; wtab[3][2] = 7'b0111111; wtab[3][1] = 7'b0111111; wtab[3][0] = 7'b0111111;
        atab[0] = 4'b1110; atab[1] = 4'b1101; atab[2] = 4'b1011; atab[3] = 4'b0111;

        rst_n = 1'b0; eq = 1'b0; force_win = 1'b0;
        tick(); tick();
        chk("rst_word", {5'b0, word_sel}, 7'd0);
        chk("rst_an", {3'b000, an}, 7'b0001110);
        chk("rst_seg", seg, 7'b0010001);
        rst_n = 1'b1;
        tick(); tick(); tick(); tick();
        chk("rst4_an", {3'b000, an}, 7'b0001101);
        chk("rst4_seg", seg, 7'b0001000);

        scan("play", 0, 12);
        chk("wrap_an", {3'b000, an}, 7'b0001110);
        chk("wrap_seg", seg, 7'b0010001);

        eq = 1'b1;
        tick();
        chk("lose_word", {5'b0, word_sel}, 7'd1);
        eq = REC;
        scan("lose", 1, 16);
        eq = 1'b0;
        tick();
        chk("sticky_word", {5'b0, word_sel}, REC ? 7'd0 : 7'd1);
        eq = 1'b1;
        tick();
        chk("relose_word", {5'b0, word_sel}, 7'd1);
        eq = REC;

        force_win = 1'b1;
        #1;
        chk("win_word", {5'b0, word_sel}, 7'd2);
        scan("win", 2, 16);
        force_win = 1'b0;
        #1;
        chk("unwin_word", {5'b0, word_sel}, 7'd1);
        chk_digit("unwin", 1);

        eq = 1'b1; rst_n = 1'b0;
        tick();
        chk("rstpri_word", {5'b0, word_sel}, 7'd0);
        chk("rstpri_an", {3'b000, an}, 7'b0001110);
        chk("rstpri_seg", seg, 7'b0010001);
        rst_n = 1'b1; eq = 1'b0;
        tick(); tick(); tick(); tick(); tick();
        chk_digit("mid_play", 0);

        // override in PLAY while the FSM still tracks eq underneath
        force_win = 1'b1;
        #1;
        chk_digit("mid_win", 2);
        eq = 1'b1;
        tick();
        chk("fw_eq_word", {5'b0, word_sel}, 7'd2);
        eq = 1'b0;
        force_win = 1'b0;
        #1;
        chk("fw_drop_word", {5'b0, word_sel}, 7'd1);
        chk_digit("fw_drop", 1);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        eq = 1'b1;
        tick();
        chk("rec1_word", {5'b0, word_sel}, 7'd1);
        eq = 1'b0;
        tick();
        chk("rec2_word", {5'b0, word_sel}, REC ? 7'd0 : 7'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/word_display_ctrl.md
Name: word_display_ctrl

Overview:
- Game-status word display for the 4-digit 7-segment display.
- A small FSM picks a status word from the "health is zero" flag; an override input can force the "win" word.
- A refresh multiplexer scans the chosen 4-character word across the digits.
- Sits between the health register/comparator and the board display pins.

Parameters:
- REFRESH_BITS, 17, width of the free-running refresh counter. Its top 2 bits select the digit; each digit is shown for 2^(REFRESH_BITS-2) cycles. Legal values are 3 or more; benches use 4.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- eq  input  1  health-equals-zero flag, sampled on clk.
- force_win  input  1  level override that displays word 2'b10.
- seg  output  7  segment drive, active low; bit0=a, bit1=b … bit6=g.
- an  output  4  digit anodes, active low, one-hot-low; an[3] is the leftmost digit.
- word_sel  output  2  currently displayed word code, for debug and verification.

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low. Reset has priority over all other inputs in the same cycle.
- FSM state register, 2 bits:
  - PLAY = 2'b00
  - LOSE = 2'b01
  - Codes 2'b10 and 2'b11 are never entered by the FSM. If reached illegally, the next edge returns to PLAY.
- Transitions:
  - PLAY -> LOSE when eq=1 at the clock edge.
  - LOSE stays LOSE regardless of eq; it is sticky until reset.
- Word select:
  - word_sel = force_win ? 2'b10 : state.
  - This mux is combinational: zero-cycle latency, no effect on the FSM state.
  - The FSM keeps tracking eq while force_win is high.
- Word table, characters listed leftmost (an[3]) to rightmost (an[0]):
  - 00 "PLAY"
  - 01 "LOSE"
  - 10 "GOOD"
  - 11 "----"
- Character segments lit (active-high set; seg outputs the inverse):
  - P = a b e f g
  - L = d e f
  - A = a b c e f g
  - Y = b c d f g
  - O = a b c d e f
  - S = a c d f g
  - E = a d e f g
  - G = a c d e f
  - D (lowercase d) = b c d e g
  - dash = g
- Refresh counter:
  - REFRESH_BITS wide, increments by 1 every cycle and wraps to 0 after all-ones.
  - Reset value 0.
- Digit select k = counter[REFRESH_BITS-1 -: 2].
  - an drives bit k low, all other bits high.
  - seg shows character position k, where k=3 is the leftmost character.
- seg and an are combinational decodes of the counter, state and force_win registers; no extra pipeline stage.
- Reset values (cycle after rst_n=0 is sampled):
  - state = PLAY, counter = 0.
  - Hence an = 4'b1110 and seg = ~Y = 7'b0010001, assuming force_win=0.
- Exactly one anode is low in every cycle, including across counter wrap; no blank cycles.
- Digit changes occur at the edge where the lower REFRESH_BITS-2 counter bits wrap to 0.
- eq or force_win changing mid-scan changes the word immediately, at the current digit position; the scan position is not reset.

Optional Feature:
- Macro WORD_RECOVER_EN.
- Defined: LOSE -> PLAY when eq=0 at the clock edge, so the display follows health recovery.
- Not defined: LOSE is sticky until rst_n=0, as specified above.
- All other behaviour is identical in both builds.

Test Plan (REFRESH_BITS=4, so each digit is held 4 cycles):
- Reset: hold rst_n=0 for 2 cycles, eq=0, force_win=0 -> word_sel=00, an=1110, seg=7'b0010001 (Y); after 4 more cycles an=1101, seg=~A=7'b0001000.
- Scan: run 16 cycles from reset -> an sequence 1110, 1101, 1011, 0111; seg shows Y, A, L, P; counter wraps back to an=1110 on cycle 16.
- Lose: pulse eq=1 for one cycle -> word_sel=01 from the next edge; a full scan shows L O S E. With eq back at 0, word_sel stays 01 (without WORD_RECOVER_EN).
- Override: force_win=1 while in LOSE -> word_sel=10 in the same cycle and digits show G O O d; drop force_win -> word_sel=01 again with no clock delay.
- Reset priority: rst_n=0 and eq=1 in the same cycle while in LOSE -> state=PLAY, counter=0.
- WORD_RECOVER_EN build: eq=1 then eq=0 -> word_sel goes 00 -> 01 -> 00, each change on consecutive edges.
